grey_stream_packer: RTL and testbench

GREY_STREAM_PACKER -- requirements
Module: grey_stream_packer

---
 rtl/grey_stream_packer.sv | 128 ++++++++++++
 tb/tb_grey_stream_packer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grey_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : grey_stream_packer
// Brief    : Packs a stream of 8-bit greyscale pixels into 32-bit words,
//            little-endian by lane, with a byte-keep mask and frame-last flag.
//            Words leave through a 2-entry output FIFO whose head drives the
//            output port directly, so in_* never reaches out_* in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module grey_stream_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_pixel,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done
);

  localparam int unsigned DEPTH = 2;

  // Assembly state: next lane to fill and the partially built word.
  logic [1:0]  lane_q;
  logic [31:0] asm_q;

  // Output FIFO storage and bookkeeping.
  logic [31:0] fifo_data_q [DEPTH];
  logic [3:0]  fifo_keep_q [DEPTH];
  logic        fifo_last_q [DEPTH];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic        frame_done_q;

  // Handshake decodes.
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] push_word;
  logic [3:0]  push_keep;

  // Ready depends only on reset and FIFO occupancy, never on out_ready.
  assign in_ready  = rst_n & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_keep  = fifo_keep_q[rd_ptr_q];
  assign out_last  = fifo_last_q[rd_ptr_q];
  assign frame_done = frame_done_q;

  assign accept = in_valid & in_ready;
  assign push   = accept & ((lane_q == 2'd3) | in_last);
  assign pop    = out_valid & out_ready;

  // Word that would be pushed this cycle: current assembly plus the incoming pixel.
  always_comb begin
    push_word = asm_q;
    push_word[{lane_q, 3'b000} +: 8] = in_pixel;
    push_keep = {(lane_q == 2'd3), (lane_q >= 2'd2), (lane_q >= 2'd1), 1'b1};
  end

  // Occupancy update; push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pixel assembly: fill lanes in order, restart from pad on every push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q <= 2'd0;
      asm_q  <= {4{PAD_BYTE}};
    end else if (push) begin
      lane_q <= 2'd0;
      asm_q  <= {4{PAD_BYTE}};
    end else if (accept) begin
      lane_q <= lane_q + 2'd1;
      asm_q  <= push_word;
    end
  end

  // Output FIFO: storage write on push, pointer/occupancy update on push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= 32'h0;
        fifo_keep_q[i] <= 4'h0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_word;
        fifo_keep_q[wr_ptr_q] <= push_keep;
        fifo_last_q[wr_ptr_q] <= in_last;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // One-cycle pulse after the frame's final word leaves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= pop & out_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_grey_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_grey_stream_packer
// Brief    : Self-checking bench for grey_stream_packer: directed vector table,
//            a pad-byte sequence on a second instance, and a randomised
//            handshake stream checked against a byte-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grey_stream_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_pixel;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_last, out_valid, frame_done;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  logic        ff_in_ready, ff_out_last, ff_out_valid, ff_frame_done;
  logic [31:0] ff_out_data;
  logic [3:0]  ff_out_keep;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  grey_stream_packer #(.PAD_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done)
  );

  grey_stream_packer #(.PAD_BYTE(8'hFF)) dut_ff (
    .clk(clk), .rst_n(rst_n), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_last(in_last), .in_ready(ff_in_ready), .out_data(ff_out_data),
    .out_keep(ff_out_keep), .out_last(ff_out_last), .out_valid(ff_out_valid),
    .out_ready(out_ready), .frame_done(ff_frame_done)
  );

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [7:0]  pix;
    logic        il;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        cmp_d;   // compare data/keep/last even when out_valid is low
    logic [31:0] e_data;
    logic [3:0]  e_keep;
    logic        e_last;
    logic        e_fd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic iv, input logic [7:0] pix,
                     input logic il, input logic ordy, input logic e_ir,
                     input logic e_ov, input logic cmp_d, input logic [31:0] e_data,
                     input logic [3:0] e_keep, input logic e_last, input logic e_fd);
    vec_t v;
    v = '{r, iv, pix, il, ordy, e_ir, e_ov, cmp_d, e_data, e_keep, e_last, e_fd};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Random-phase model state
  logic [8:0]  exp_q[$];
  logic        held;
  logic [31:0] held_data;
  logic [3:0]  held_keep;
  logic        held_last;

  initial begin
    int sent;
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; in_pixel = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // rst  iv  pix    il  or  eir eov cd  data          keep  last fd
    add(0, 0, 8'h00, 0, 0, 0, 0, 1, 32'h00000000, 4'h0, 0, 0); // 0 reset
    add(1, 0, 8'h00, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 1 release
    add(1, 1, 8'h11, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 2
    add(1, 1, 8'h22, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h33, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h44, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 5 push
    add(1, 0, 8'h00, 0, 1, 1, 1, 0, 32'h44332211, 4'hF, 0, 0); // 6
    add(1, 1, 8'hA0, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 7
    add(1, 1, 8'hA1, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'hA2, 1, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 9 push
    add(1, 0, 8'h00, 0, 1, 1, 1, 0, 32'h00A2A1A0, 4'h7, 1, 0); // 10
    add(1, 0, 8'h00, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 1); // 11 frame_done
    add(1, 0, 8'h00, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 12
    add(1, 1, 8'h01, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 13 streaming
    add(1, 1, 8'h02, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h03, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h04, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h05, 0, 1, 1, 1, 0, 32'h04030201, 4'hF, 0, 0); // 17
    add(1, 1, 8'h06, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h07, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h08, 1, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 20
    add(1, 0, 8'h00, 0, 1, 1, 1, 0, 32'h08070605, 4'hF, 1, 0); // 21
    add(1, 0, 8'h00, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 1); // 22
    add(1, 1, 8'h10, 0, 0, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 23 backpressure
    add(1, 1, 8'h11, 0, 0, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h12, 0, 0, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h13, 0, 0, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h14, 0, 0, 1, 1, 0, 32'h13121110, 4'hF, 0, 0); // 27
    add(1, 1, 8'h15, 0, 0, 1, 1, 0, 32'h13121110, 4'hF, 0, 0);
    add(1, 1, 8'h16, 0, 0, 1, 1, 0, 32'h13121110, 4'hF, 0, 0);
    add(1, 1, 8'h17, 0, 0, 1, 1, 0, 32'h13121110, 4'hF, 0, 0); // 30 FIFO full
    add(1, 1, 8'h18, 0, 0, 0, 1, 0, 32'h13121110, 4'hF, 0, 0); // 31 9th offer
    add(1, 1, 8'h19, 0, 0, 0, 1, 0, 32'h13121110, 4'hF, 0, 0);
    add(1, 1, 8'h1A, 0, 0, 0, 1, 0, 32'h13121110, 4'hF, 0, 0);
    add(1, 1, 8'h1B, 0, 0, 0, 1, 0, 32'h13121110, 4'hF, 0, 0); // 34
    add(1, 1, 8'h18, 0, 1, 0, 1, 0, 32'h13121110, 4'hF, 0, 0); // 35 drain
    add(1, 1, 8'h18, 0, 1, 1, 1, 0, 32'h17161514, 4'hF, 0, 0); // 36
    add(1, 0, 8'h00, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h19, 1, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 38
    add(1, 0, 8'h00, 0, 1, 1, 1, 0, 32'h00001918, 4'h3, 1, 0);
    add(1, 0, 8'h00, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 1); // 40
    add(1, 1, 8'hAA, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 41 mid-frame reset
    add(1, 1, 8'hBB, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(0, 1, 8'hCC, 0, 1, 0, 0, 0, 32'h0,        4'h0, 0, 0); // 43
    add(1, 0, 8'h00, 0, 1, 1, 0, 1, 32'h00000000, 4'h0, 0, 0); // 44
    add(1, 1, 8'h01, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h02, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h03, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h04, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 0, 8'h00, 0, 1, 1, 1, 0, 32'h04030201, 4'hF, 0, 0); // 49
    add(1, 1, 8'h55, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 50 idle gaps
    add(1, 0, 8'h00, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 0, 8'h00, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h66, 1, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 0, 8'h00, 0, 1, 1, 1, 0, 32'h00006655, 4'h3, 1, 0); // 54
    add(1, 0, 8'h00, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 1); // 55
    add(1, 1, 8'h71, 0, 0, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 56 push+pop
    add(1, 1, 8'h72, 0, 0, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h73, 0, 0, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h74, 0, 0, 1, 0, 0, 32'h0,        4'h0, 0, 0);
    add(1, 1, 8'h75, 0, 0, 1, 1, 0, 32'h74737271, 4'hF, 0, 0); // 60
    add(1, 1, 8'h76, 0, 0, 1, 1, 0, 32'h74737271, 4'hF, 0, 0);
    add(1, 1, 8'h77, 0, 0, 1, 1, 0, 32'h74737271, 4'hF, 0, 0);
    add(1, 1, 8'h78, 0, 1, 1, 1, 0, 32'h74737271, 4'hF, 0, 0); // 63
    add(1, 0, 8'h00, 0, 1, 1, 1, 0, 32'h78777675, 4'hF, 0, 0); // 64
    add(1, 0, 8'h00, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0, 0); // 65

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n     = vecs[i].rst_n;
      in_valid  = vecs[i].iv;
      in_pixel  = vecs[i].pix;
      in_last   = vecs[i].il;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("row%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
      chk($sformatf("row%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("row%0d frame_done", i), {31'd0, frame_done}, {31'd0, vecs[i].e_fd});
      if (vecs[i].e_ov || vecs[i].cmp_d) begin
        chk($sformatf("row%0d out_data", i), out_data, vecs[i].e_data);
        chk($sformatf("row%0d out_keep", i), {28'd0, out_keep}, {28'd0, vecs[i].e_keep});
        chk($sformatf("row%0d out_last", i), {31'd0, out_last}, {31'd0, vecs[i].e_last});
      end
    end

    // Single-pixel frame on both pad settings.
    @(negedge clk);
    in_valid = 1'b1; in_pixel = 8'h5A; in_last = 1'b1; out_ready = 1'b1;
    #1;
    chk("single ff in_ready", {31'd0, ff_in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    chk("single ff out_valid", {31'd0, ff_out_valid}, 32'd1);
    chk("single ff out_data", ff_out_data, 32'hFFFFFF5A);
    chk("single ff out_keep", {28'd0, ff_out_keep}, 32'h1);
    chk("single ff out_last", {31'd0, ff_out_last}, 32'd1);
    chk("single 00 out_data", out_data, 32'h0000005A);
    @(negedge clk);
    #1;
    chk("single ff frame_done", {31'd0, ff_frame_done}, 32'd1);
    chk("single ff out_valid after", {31'd0, ff_out_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("single ff frame_done width", {31'd0, ff_frame_done}, 32'd0);

    // Randomised handshakes over 1000 pixels, checked against a byte queue.
    sent = 0;
    held = 1'b0;
    held_data = 32'h0; held_keep = 4'h0; held_last = 1'b0;
    for (cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_pixel  = 8'($urandom);
      in_last   = (sent == 999) || ($urandom_range(0, 6) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (held) begin
        chk("rand hold data", out_data, held_data);
        chk("rand hold keep", {28'd0, out_keep}, {28'd0, held_keep});
        chk("rand hold valid", {31'd0, out_valid}, 32'd1);
      end
      if (out_valid && out_ready) begin
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
        logic [8:0]  e;
        ed = 32'h0; ek = 4'h0; el = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!el && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ed[k*8 +: 8] = e[7:0];
            ek[k] = 1'b1;
            el = e[8];
          end
        end
        chk("rand word data", out_data, ed);
        chk("rand word keep", {28'd0, out_keep}, {28'd0, ek});
        chk("rand word last", {31'd0, out_last}, {31'd0, el});
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      held_keep = out_keep;
      held_last = out_last;
      if (in_valid && in_ready) begin
        exp_q.push_back({in_last, in_pixel});
        sent++;
      end
      if (sent == 1000 && exp_q.size() == 0 && !out_valid) break;
    end
    chk("rand pixels accepted", sent, 1000);
    chk("rand drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
